// File: rtl/mux_rr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mux_rr_pkg: mode encodings and round-robin pick helper          |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
package mux_rr_pkg;

    localparam logic MODE_SEL  = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    // Helper is sized for the largest supported channel count; callers zero-extend.
    localparam int   RR_MAX_CH = 32;
    localparam int   RR_IDX_W  = 5;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_CH-1:0] valid,
        input logic [RR_IDX_W-1:0]  ptr,
        input logic [RR_IDX_W:0]    n_ch
    );
        rr_pick_t          res;
        logic [RR_IDX_W:0] step;
        logic [RR_IDX_W:0] cand;
        res = '0;
        for (int i = 1; i <= RR_MAX_CH; i++) begin
            step = (RR_IDX_W+1)'(i);
            cand = ({1'b0, ptr} + step) % n_ch;
            if (step <= n_ch && !res.found && valid[cand[RR_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[RR_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_rr_nx1_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | rr_arbiter: first valid channel after ptr, wrapping, with found |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module rr_arbiter
    import mux_rr_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_CH-1:0]  valid,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    localparam logic [RR_IDX_W:0] C_N_CH = (RR_IDX_W+1)'(N_CH);

    rr_pick_t w_pick;
    logic     w_unused_idx;

    assign w_pick       = rr_pick(RR_MAX_CH'(valid), RR_IDX_W'(ptr), C_N_CH);
    assign found        = w_pick.found;
    assign idx          = w_pick.idx[SEL_W-1:0];
    assign w_unused_idx = ^w_pick.idx;

endmodule
`default_nettype wire

// File: rtl/mux_rr_nx1.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mux_rr_nx1: registered N:1 mux, explicit-select or round-robin  |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module mux_rr_nx1
    import mux_rr_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err
);

    logic [WIDTH-1:0] w_ch_data [N_CH];
    logic [SEL_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_ch;
    logic             r_out_valid;
    logic             r_sel_err;
    logic             w_load_en;
    logic             w_sel_ok;
    logic             w_rr_found;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_granted;
    logic [SEL_W-1:0] w_grant;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_unpack
            assign w_ch_data[k] = in_data[k*WIDTH +: WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .valid (in_valid),
        .ptr   (r_ptr),
        .found (w_rr_found),
        .idx   (w_rr_idx)
    );

    assign w_load_en = !r_out_valid || out_ready;
    assign w_sel_ok  = 32'(sel) < 32'(N_CH);

    always_comb begin
        w_granted = 1'b0;
        w_grant   = '0;
        if (mode == MODE_SEL) begin
            // Out-of-range sel must not index in_valid beyond N_CH.
            w_granted = w_sel_ok && in_valid[sel];
            w_grant   = sel;
        end else begin
            w_granted = w_rr_found;
            w_grant   = w_rr_idx;
        end
    end

    assign in_ready = (w_load_en && w_granted) ? (N_CH'(1) << w_grant) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_sel_err   <= 1'b0;
            r_ptr       <= SEL_W'(N_CH - 1);
        end else begin
            r_sel_err <= (mode == MODE_SEL) && !w_sel_ok && w_load_en;
            if (w_load_en) begin
                if (w_granted) begin
                    r_out_data  <= w_ch_data[w_grant];
                    r_out_ch    <= w_grant;
                    r_out_valid <= 1'b1;
                    if (mode == MODE_RR) begin
                        r_ptr <= w_grant;
                    end
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_nx1.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_mux_rr_nx1: scoreboard bench for 4-channel and 5-channel mux |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module tb_mux_rr_nx1;

    logic        clk;
    logic        reset;

    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
    logic        sel_err;

    logic        mode5;
    logic [2:0]  sel5;
    logic [39:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic [7:0]  out_data5;
    logic [2:0]  out_ch5;
    logic        out_valid5;
    logic        out_ready5;
    logic        sel_err5;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [9:0]  exp_q[$];

    mux_rr_nx1 #(.N_CH(4), .WIDTH(8)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    mux_rr_nx1 #(.N_CH(5), .WIDTH(8)) u_dut5 (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode5),
        .sel       (sel5),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .out_data  (out_data5),
        .out_ch    (out_ch5),
        .out_valid (out_valid5),
        .out_ready (out_ready5),
        .sel_err   (sel_err5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one pop per accepted output word.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_word: got ch=%0d data=%0h with nothing expected", out_ch, out_data);
            end else begin
                check("out_word", {22'd0, out_ch, out_data}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        n_vec++;
        n_miss++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        logic [1:0] rr_seq [5];
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        reset      = 1'b0;
        mode       = 1'b0;
        sel        = 2'd0;
        in_data    = {8'h13, 8'h12, 8'h11, 8'h10};
        in_valid   = 4'b0000;
        out_ready  = 1'b0;
        mode5      = 1'b0;
        sel5       = 3'd0;
        in_data5   = {8'h24, 8'h23, 8'h22, 8'h21, 8'h20};
        in_valid5  = 5'b00000;
        out_ready5 = 1'b0;

        // Reset state
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_ch", {30'd0, out_ch}, 32'd0);
        check("rst_sel_err", {31'd0, sel_err}, 32'd0);
        check("rst_in_ready", {28'd0, in_ready}, 32'd0);
        check("rst_out_valid5", {31'd0, out_valid5}, 32'd0);

        // Explicit select, ch1
        mode          = 1'b0;
        sel           = 2'd1;
        in_data[15:8] = 8'hA5;
        in_valid      = 4'b0010;
        out_ready     = 1'b1;
        #1;
        check("sel_in_ready", {28'd0, in_ready}, 32'h2);
        exp_q.push_back({2'd1, 8'hA5});
        @(posedge clk); #1;
        in_valid = 4'b0000;
        check("sel_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
        in_data[15:8] = 8'h11;

        // Round-robin, all valid, back-to-back
        mode     = 1'b1;
        in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_in_ready", {28'd0, in_ready}, 32'd1 << rr_seq[k]);
            exp_q.push_back({rr_seq[k], 8'h10 + 8'(rr_seq[k])});
            @(posedge clk); #1;
        end
        in_valid = 4'b0000;
        @(posedge clk); #1;

        // Round-robin with back-pressure: ptr=0, so ch1, then ch3, then ch1
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        #1;
        check("bp_first_ready", {28'd0, in_ready}, 32'h2);
        exp_q.push_back({2'd1, 8'h11});
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_stall_ready", {28'd0, in_ready}, 32'd0);
            check("bp_stall_data", {24'd0, out_data}, 32'h11);
            check("bp_stall_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_ch3_ready", {28'd0, in_ready}, 32'h8);
        exp_q.push_back({2'd3, 8'h13});
        @(posedge clk); #1;
        check("bp_ch1_ready", {28'd0, in_ready}, 32'h2);
        exp_q.push_back({2'd1, 8'h11});
        @(posedge clk); #1;
        in_valid = 4'b0000;
        @(posedge clk); #1;

        // N_CH=5: out-of-range select
        mode5      = 1'b0;
        sel5       = 3'd6;
        in_valid5  = 5'b11111;
        out_ready5 = 1'b1;
        #1;
        check("err_in_ready5", {27'd0, in_ready5}, 32'd0);
        check("err_before5", {31'd0, sel_err5}, 32'd0);
        @(posedge clk); #1;
        check("err_pulse5", {31'd0, sel_err5}, 32'd1);
        check("err_out_valid5", {31'd0, out_valid5}, 32'd0);
        sel5      = 3'd1;
        in_valid5 = 5'b00000;
        @(posedge clk); #1;
        check("err_clear5", {31'd0, sel_err5}, 32'd0);
        // N_CH=5 round-robin from reset ptr=4 wraps to ch4 only when ch0..3 idle
        mode5     = 1'b1;
        in_valid5 = 5'b10000;
        #1;
        check("rr5_in_ready", {27'd0, in_ready5}, 32'h10);
        @(posedge clk); #1;
        in_valid5 = 5'b00000;
        check("rr5_out_ch", {29'd0, out_ch5}, 32'd4);
        check("rr5_out_data", {24'd0, out_data5}, 32'h24);

        // Reset mid-stream with a held word
        mode      = 1'b1;
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 4'b0000;
        check("held_valid", {31'd0, out_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        reset     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("post_rst_ready", {28'd0, in_ready}, 32'h1);
        exp_q.push_back({2'd0, 8'h10});
        @(posedge clk); #1;
        check("post_rst_ready2", {28'd0, in_ready}, 32'h2);
        exp_q.push_back({2'd1, 8'h11});
        @(posedge clk); #1;
        in_valid = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
